// File: rtl/udt_tx_sched.sv
// Transmit packet scheduler for the UDT core: fixed-priority arbitration with data fairness,
// valid/ready hand-off to the encoder and close tracking. Optional macro: UDT_KEEPALIVE_TIMER_EN.
module udt_tx_sched #(
  parameter int unsigned KA_PERIOD  = 100000,
  parameter int unsigned CTRL_BURST = 4
) (
  input  logic       clk,
  input  logic       core_rst_n,
  input  logic       sched_en,
  input  logic       req_handshake,
  input  logic       req_keep_live,
  input  logic       req_ack,
  input  logic       req_nak,
  input  logic       req_ack2,
  input  logic       req_close,
  input  logic       data_req,
  output logic       sel_valid,
  input  logic       sel_ready,
  output logic [2:0] sel_type,
  output logic       data_gnt,
  input  logic       pkt_done,
  output logic       busy,
  output logic       closed,
  output logic [5:0] pend
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_CLOSED} state_e;

  localparam logic [2:0] T_HS = 3'd0, T_KA = 3'd1, T_ACK = 3'd2, T_NAK = 3'd3;
  localparam logic [2:0] T_CLOSE = 3'd5, T_ACK2 = 3'd6, T_DATA = 3'd7;
  localparam int P_KA = 0, P_ACK2 = 1, P_ACK = 2, P_NAK = 3, P_HS = 4, P_CLOSE = 5;
  localparam int RUN_W = $clog2(CTRL_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CTRL_BURST);

  state_e           state_q, state_d;
  logic             sel_valid_q, sel_valid_d;
  logic [2:0]       sel_type_q, sel_type_d;
  logic             data_gnt_q, data_gnt_d;
  logic             busy_q, busy_d;
  logic             closed_q, closed_d;
  logic [5:0]       pend_q, pend_d;
  logic [RUN_W-1:0] ctrl_run_q, ctrl_run_d;

  logic       accept;
  logic       ka_src;
  logic       cand_valid;
  logic [2:0] cand_type;
  logic [5:0] clr;

  assign accept = sel_valid_q & sel_ready;

`ifdef UDT_KEEPALIVE_TIMER_EN
  logic [31:0] ka_cnt_q, ka_cnt_d;
  logic        ka_fire;

  always_comb begin
    ka_fire  = 1'b0;
    ka_cnt_d = ka_cnt_q;
    if (accept) begin
      ka_cnt_d = '0;
    end else if (state_q != S_CLOSED) begin
      if (ka_cnt_q == 32'(KA_PERIOD - 1)) begin
        ka_fire  = 1'b1;
        ka_cnt_d = '0;
      end else begin
        ka_cnt_d = ka_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!core_rst_n) ka_cnt_q <= '0;
    else             ka_cnt_q <= ka_cnt_d;
  end

  assign ka_src = req_keep_live | ka_fire;
`else
  wire [31:0] ka_period_unused = KA_PERIOD;
  assign ka_src = req_keep_live;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    cand_valid = 1'b1;
    cand_type  = T_DATA;
    if      (pend_q[P_CLOSE])                   cand_type = T_CLOSE;
    else if (pend_q[P_HS])                      cand_type = T_HS;
    else if (data_req && ctrl_run_q == RUN_MAX) cand_type = T_DATA;
    else if (pend_q[P_NAK])                     cand_type = T_NAK;
    else if (pend_q[P_ACK])                     cand_type = T_ACK;
    else if (pend_q[P_ACK2])                    cand_type = T_ACK2;
    else if (pend_q[P_KA])                      cand_type = T_KA;
    else if (data_req)                          cand_type = T_DATA;
    else                                        cand_valid = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    sel_type_d = sel_type_q;
    unique case (state_q)
      S_IDLE: begin
        if (sched_en && cand_valid) begin
          state_d    = S_ISSUE;
          sel_type_d = cand_type;
        end
      end
      S_ISSUE: if (accept) state_d = S_BUSY;
      S_BUSY:  if (pkt_done) state_d = (sel_type_q == T_CLOSE) ? S_CLOSED : S_IDLE;
      S_CLOSED: begin
        // Only a handshake may reopen the connection.
        if (sched_en && pend_q[P_HS]) begin
          state_d    = S_ISSUE;
          sel_type_d = T_HS;
        end
      end
    endcase

    sel_valid_d = (state_d == S_ISSUE);
    busy_d      = (state_d == S_ISSUE) || (state_d == S_BUSY);
    closed_d    = (state_d == S_CLOSED);
    // Registered grant: high in the first BUSY cycle after a data issue is taken.
    data_gnt_d  = accept && (sel_type_q == T_DATA);
  end

  always_comb begin
    clr = '0;
    if (accept) begin
      case (sel_type_q)
        T_CLOSE: clr[P_CLOSE] = 1'b1;
        T_HS:    clr[P_HS]    = 1'b1;
        T_NAK:   clr[P_NAK]   = 1'b1;
        T_ACK:   clr[P_ACK]   = 1'b1;
        T_ACK2:  clr[P_ACK2]  = 1'b1;
        T_KA:    clr[P_KA]    = 1'b1;
        default: ;
      endcase
    end
    // A pulse in the acceptance cycle wins over the clear, so no request is lost.
    pend_d = (pend_q & ~clr) | {req_close, req_handshake, req_nak, req_ack, req_ack2, ka_src};
    if (state_q == S_CLOSED) pend_d = {1'b0, pend_q[P_HS] | req_handshake, 4'b0000};

    ctrl_run_d = ctrl_run_q;
    if (!data_req) begin
      ctrl_run_d = '0;
    end else if (accept) begin
      if (sel_type_q == T_DATA) begin
        ctrl_run_d = '0;
      end else if ((sel_type_q == T_NAK || sel_type_q == T_ACK || sel_type_q == T_ACK2 ||
                    sel_type_q == T_KA) && ctrl_run_q != RUN_MAX) begin
        ctrl_run_d = ctrl_run_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!core_rst_n) begin
      state_q     <= S_IDLE;
      sel_valid_q <= 1'b0;
      sel_type_q  <= 3'd0;
      data_gnt_q  <= 1'b0;
      busy_q      <= 1'b0;
      closed_q    <= 1'b0;
      pend_q      <= '0;
      ctrl_run_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_valid_q <= sel_valid_d;
      sel_type_q  <= sel_type_d;
      data_gnt_q  <= data_gnt_d;
      busy_q      <= busy_d;
      closed_q    <= closed_d;
      pend_q      <= pend_d;
      ctrl_run_q  <= ctrl_run_d;
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_type  = sel_type_q;
  assign data_gnt  = data_gnt_q;
  assign busy      = busy_q;
  assign closed    = closed_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_udt_tx_sched.sv
// Directed self-checking bench for udt_tx_sched; with UDT_KEEPALIVE_TIMER_EN it exercises the timer.
module tb_udt_tx_sched;

  logic       clk = 1'b0;
  logic       core_rst_n;
  logic       sched_en;
  logic       req_handshake, req_keep_live, req_ack, req_nak, req_ack2, req_close;
  logic       data_req;
  logic       sel_valid;
  logic       sel_ready;
  logic [2:0] sel_type;
  logic       data_gnt;
  logic       pkt_done;
  logic       busy;
  logic       closed;
  logic [5:0] pend;

  int checks = 0;
  int errors = 0;

  udt_tx_sched #(.KA_PERIOD(64), .CTRL_BURST(4)) dut (
    .clk(clk), .core_rst_n(core_rst_n), .sched_en(sched_en),
    .req_handshake(req_handshake), .req_keep_live(req_keep_live), .req_ack(req_ack),
    .req_nak(req_nak), .req_ack2(req_ack2), .req_close(req_close), .data_req(data_req),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_type(sel_type), .data_gnt(data_gnt),
    .pkt_done(pkt_done), .busy(busy), .closed(closed), .pend(pend)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      if (sel_valid === 1'b1) cnt++;
      step(1);
    end
  endtask

  // Wait for an offer, check it, accept it (sel_ready=1), optionally pulse req_ack while
  // BUSY, then complete the packet. Returns in the first IDLE cycle after pkt_done.
  task automatic serve(input string tag, input logic [2:0] exp_type, input int ack_pulses);
    int n;
    n = 0;
    while (sel_valid !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    check({tag, "_valid"}, 32'(sel_valid), 32'd1);
    check({tag, "_type"}, 32'(sel_type), 32'(exp_type));
    step(1);
    check({tag, "_gnt"}, 32'(data_gnt), (exp_type == 3'd7) ? 32'd1 : 32'd0);
    for (int i = 0; i < ack_pulses; i++) begin
      req_ack = 1'b1;
      step(1);
      req_ack = 1'b0;
      step(1);
    end
    pkt_done = 1'b1;
    step(1);
    pkt_done = 1'b0;
  endtask

  initial begin
    int cnt;
    int bad;
    core_rst_n = 1'b0; sched_en = 1'b1; sel_ready = 1'b1; pkt_done = 1'b0; data_req = 1'b0;
    req_handshake = 1'b0; req_keep_live = 1'b0; req_ack = 1'b0;
    req_nak = 1'b0; req_ack2 = 1'b0; req_close = 1'b0;
    step(2);
    check("rst_valid", 32'(sel_valid), 32'd0);
    check("rst_type", 32'(sel_type), 32'd0);
    check("rst_gnt", 32'(data_gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_closed", 32'(closed), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    core_rst_n = 1'b1;

`ifdef UDT_KEEPALIVE_TIMER_EN
    cnt = 0;
    while (sel_valid !== 1'b1 && cnt < 200) begin
      step(1);
      cnt++;
    end
    check("ka1_delay", 32'(cnt), 32'd65);
    check("ka1_type", 32'(sel_type), 32'd1);
    step(1);
    pkt_done = 1'b1;
    step(1);
    pkt_done = 1'b0;
    cnt = 1;
    while (sel_valid !== 1'b1 && cnt < 200) begin
      step(1);
      cnt++;
    end
    check("ka2_delay", 32'(cnt), 32'd65);
    check("ka2_type", 32'(sel_type), 32'd1);
`else
    count_valid(200, cnt);
    check("no_ka_offer", 32'(cnt), 32'd0);

    // Single ACK: request at N, pend at N+1, offer at N+2, busy until pkt_done.
    req_ack = 1'b1;
    step(1);
    req_ack = 1'b0;
    check("ack_pend", 32'(pend), 32'b000100);
    check("ack_no_early", 32'(sel_valid), 32'd0);
    step(1);
    check("ack_valid", 32'(sel_valid), 32'd1);
    check("ack_type", 32'(sel_type), 32'd2);
    check("ack_busy_issue", 32'(busy), 32'd1);
    step(1);
    check("ack_drop_valid", 32'(sel_valid), 32'd0);
    check("ack_busy", 32'(busy), 32'd1);
    check("ack_pend_clr", 32'(pend), 32'd0);
    step(6);
    pkt_done = 1'b1;
    check("ack_busy_done", 32'(busy), 32'd1);
    step(1);
    pkt_done = 1'b0;
    check("ack_idle", 32'(busy), 32'd0);
    step(1);
    check("ack_no_reissue", 32'(sel_valid), 32'd0);

    // Priority and coalescing.
    req_ack = 1'b1; req_nak = 1'b1; req_handshake = 1'b1;
    step(1);
    req_ack = 1'b0; req_nak = 1'b0; req_handshake = 1'b0;
    check("prio_pend", 32'(pend), 32'b011100);
    serve("prio_hs", 3'd0, 3);
    serve("prio_nak", 3'd3, 0);
    serve("prio_ack", 3'd2, 0);
    count_valid(10, cnt);
    check("prio_one_ack", 32'(cnt), 32'd0);
    check("prio_pend_empty", 32'(pend), 32'd0);

    // sched_en gates new issues; the request stays pending.
    sched_en = 1'b0;
    req_ack2 = 1'b1;
    step(1);
    req_ack2 = 1'b0;
    count_valid(5, cnt);
    check("en_off_offer", 32'(cnt), 32'd0);
    check("en_off_pend", 32'(pend), 32'b000010);
    sched_en = 1'b1;
    serve("en_on_ack2", 3'd6, 0);

    // Fairness: continuous nak/ack with data ready gives 4 controls, then forced data.
    req_ack = 1'b1; req_nak = 1'b1;
    step(1);
    data_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) serve("fair_ctrl", 3'd3, 0);
      serve("fair_data", 3'd7, 0);
    end
    req_ack = 1'b0; req_nak = 1'b0; data_req = 1'b0;
    serve("fair_drain_nak", 3'd3, 0);
    serve("fair_drain_ack", 3'd2, 0);

    // Close, then only a handshake reopens.
    req_close = 1'b1;
    step(1);
    req_close = 1'b0;
    serve("close", 3'd5, 0);
    check("closed_set", 32'(closed), 32'd1);
    req_ack = 1'b1; data_req = 1'b1;
    step(1);
    req_ack = 1'b0;
    count_valid(10, cnt);
    check("closed_no_offer", 32'(cnt), 32'd0);
    check("closed_pend", 32'(pend), 32'd0);
    check("closed_hold", 32'(closed), 32'd1);
    req_handshake = 1'b1;
    step(1);
    req_handshake = 1'b0;
    serve("reopen_hs", 3'd0, 0);
    check("reopen_closed", 32'(closed), 32'd0);
    serve("reopen_data", 3'd7, 0);
    data_req = 1'b0;

    // Backpressure: offer must stay stable for 50 cycles regardless of other inputs.
    sel_ready = 1'b0;
    req_nak = 1'b1;
    step(1);
    req_nak = 1'b0;
    step(1);
    check("bp_valid", 32'(sel_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      req_ack = i[0];
      req_handshake = ~i[0];
      sched_en = (i < 25);
      step(1);
      if (!(sel_valid === 1'b1 && sel_type === 3'd3)) bad++;
    end
    req_ack = 1'b0; req_handshake = 1'b0; sched_en = 1'b1;
    check("bp_stable", 32'(bad), 32'd0);
    sel_ready = 1'b1;
    step(1);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_pend", 32'(pend), 32'b010100);

    // Synchronous reset while BUSY.
    core_rst_n = 1'b0;
    step(1);
    check("mid_rst_valid", 32'(sel_valid), 32'd0);
    check("mid_rst_type", 32'(sel_type), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_closed", 32'(closed), 32'd0);
    check("mid_rst_gnt", 32'(data_gnt), 32'd0);
    check("mid_rst_pend", 32'(pend), 32'd0);
    core_rst_n = 1'b1;
    count_valid(8, cnt);
    check("post_rst_quiet", 32'(cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
